// File: rtl/sd_data_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_data_pkg                                                                |
// | Shared types and constants for the SD data path (block scheduler et al.)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sd_data_pkg;

    localparam int unsigned DEF_BLOCK_WORDS = 128;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_CRC     = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ACK       = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } sd_blk_state_t;

    // A write needs a full block already queued; a read needs a block of free space.
    function automatic logic fifo_block_ready(
        input logic        write,
        input int unsigned level,
        input int unsigned depth,
        input int unsigned block_words
    );
        logic ready;
        if (write) begin
            ready = (level >= block_words);
        end else begin
            ready = (depth >= level) && ((depth - level) >= block_words);
        end
        return ready;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_timeout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_timeout_counter                                                         |
// | Loadable down-counter that stops at zero and flags it.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sd_timeout_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_decrement,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_decrement && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sd_block_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_block_scheduler                                                         |
// | Sequences multi-block SD transfers between data FIFO and physical layer.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sd_block_scheduler
    import sd_data_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int          FIFO_AW     = 8,
    parameter int          COUNT_W     = 16,
    parameter int          TIMEOUT_W   = 16
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic                 iWriteRead,
    input  logic [COUNT_W-1:0]   iBlockCount,
    input  logic                 iTimeout_enable,
    input  logic [TIMEOUT_W-1:0] iTimeout_reg,
    input  logic [FIFO_AW:0]     iFifo_level,
    input  logic                 iAbort,
    input  logic                 iComplete,
    input  logic                 iCrc_error,
    output logic                 oSend,
    output logic                 oAck,
    output logic                 oIdle,
    output logic                 oBusy,
    output logic [COUNT_W-1:0]   oBlocks_done,
    output logic                 oData_transfer_complete,
    output logic                 oError,
    output logic [1:0]           oError_code
);

    localparam int unsigned c_fifo_depth = 2 ** FIFO_AW;

    sd_blk_state_t        r_state;
    sd_blk_state_t        w_next_state;
    logic                 r_write_read;
    logic [COUNT_W-1:0]   r_block_count;
    logic                 r_timeout_en;
    logic [TIMEOUT_W-1:0] r_timeout_val;
    logic [COUNT_W-1:0]   r_blocks_done;
    logic [1:0]           r_error_code;

    logic                 w_fifo_ready;
    logic                 w_tmo_zero;
    logic                 w_timeout_hit;
    logic                 w_tmo_load;
    logic [TIMEOUT_W-1:0] w_tmo_load_value;
    logic                 w_tmo_decrement;
    logic [COUNT_W-1:0]   w_blocks_done_inc;
    logic                 w_err_set;
    logic [1:0]           w_err_value;

    assign w_fifo_ready  = fifo_block_ready(r_write_read, 32'(iFifo_level),
                                            c_fifo_depth, BLOCK_WORDS);
    assign w_timeout_hit = r_timeout_en && w_tmo_zero;

    // Saturating increment: never count past the requested block total.
    assign w_blocks_done_inc = (r_blocks_done < r_block_count) ?
                               (r_blocks_done + COUNT_W'(1)) : r_blocks_done;

    always_comb begin
        w_next_state = r_state;
        w_err_set    = 1'b0;
        w_err_value  = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_next_state = (iBlockCount == '0) ? ST_DONE : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (iAbort) begin
                    w_next_state = ST_ERROR;
                    w_err_set    = 1'b1;
                    w_err_value  = ERR_ABORT;
                end else if (w_fifo_ready) begin
                    w_next_state = ST_SEND;
                end else if (w_timeout_hit) begin
                    w_next_state = ST_ERROR;
                    w_err_set    = 1'b1;
                    w_err_value  = ERR_TIMEOUT;
                end
            end
            ST_SEND: begin
                if (iAbort) begin
                    w_next_state = ST_ERROR;
                    w_err_set    = 1'b1;
                    w_err_value  = ERR_ABORT;
                end else begin
                    w_next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // A completion arriving as the counter hits zero beats the timeout.
                if (iAbort) begin
                    w_next_state = ST_ERROR;
                    w_err_set    = 1'b1;
                    w_err_value  = ERR_ABORT;
                end else if (iComplete) begin
                    if (iCrc_error) begin
                        w_next_state = ST_ERROR;
                        w_err_set    = 1'b1;
                        w_err_value  = ERR_CRC;
                    end else begin
                        w_next_state = ST_ACK;
                    end
                end else if (w_timeout_hit) begin
                    w_next_state = ST_ERROR;
                    w_err_set    = 1'b1;
                    w_err_value  = ERR_TIMEOUT;
                end
            end
            ST_ACK: begin
                w_next_state = (w_blocks_done_inc == r_block_count) ? ST_DONE : ST_CHECK;
            end
            ST_DONE:  w_next_state = ST_IDLE;
            ST_ERROR: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // The counter holds the full timeout during the SEND cycle and counts from there.
    assign w_tmo_load = ((r_state == ST_IDLE) && iStart) ||
                        (r_state == ST_ACK) ||
                        ((r_state == ST_CHECK) && (w_next_state == ST_SEND));
    assign w_tmo_load_value = (r_state == ST_IDLE) ? iTimeout_reg : r_timeout_val;
    assign w_tmo_decrement  = (r_state == ST_CHECK) || (r_state == ST_SEND) ||
                              (r_state == ST_WAIT_DONE);

    sd_timeout_counter #(
        .WIDTH (TIMEOUT_W)
    ) u_timeout (
        .clk          (iClock),
        .rst          (iReset),
        .i_load       (w_tmo_load),
        .i_load_value (w_tmo_load_value),
        .i_decrement  (w_tmo_decrement),
        .o_zero       (w_tmo_zero)
    );

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state       <= ST_IDLE;
            r_write_read  <= 1'b0;
            r_block_count <= '0;
            r_timeout_en  <= 1'b0;
            r_timeout_val <= '0;
            r_blocks_done <= '0;
            r_error_code  <= ERR_NONE;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && iStart) begin
                r_write_read  <= iWriteRead;
                r_block_count <= iBlockCount;
                r_timeout_en  <= iTimeout_enable;
                r_timeout_val <= iTimeout_reg;
                r_blocks_done <= '0;
                r_error_code  <= ERR_NONE;
            end
            if (r_state == ST_ACK) begin
                r_blocks_done <= w_blocks_done_inc;
            end
            if (w_err_set) begin
                r_error_code <= w_err_value;
            end
        end
    end

    assign oSend                   = (r_state == ST_SEND) && !iAbort;
    assign oAck                    = (r_state == ST_ACK);
    assign oIdle                   = (r_state == ST_IDLE);
    assign oBusy                   = (r_state != ST_IDLE);
    assign oBlocks_done            = r_blocks_done;
    assign oData_transfer_complete = (r_state == ST_DONE);
    assign oError                  = (r_state == ST_ERROR);
    assign oError_code             = r_error_code;

endmodule
`default_nettype wire
